// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: price/stock table, item latch, note credit
// accumulation, and dispense-with-change or full-refund completion.
module vend_tbl_entry #(
  parameter int AMT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic             dec,
  input  logic [AMT_W-1:0] price_d,
  input  logic [7:0]       stock_d,
  output logic [AMT_W-1:0] price,
  output logic [7:0]       stock
);
  // A host write in the same cycle as a dispense decrement takes priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      price <= '0;
      stock <= '0;
    end else if (we) begin
      price <= price_d;
      stock <= stock_d;
    end else if (dec && stock != 8'd0) begin
      stock <= stock - 8'd1;
    end
  end
endmodule

module vend_txn_ctrl #(
  parameter int NUM_ITEMS   = 64,
  parameter int AMT_W       = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_ITEMS)-1:0] cfg_addr,
  input  logic [AMT_W-1:0]             cfg_price,
  input  logic [7:0]                   cfg_stock,
  input  logic                         item_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] item_code,
  input  logic                         note_valid,
  input  logic [AMT_W-1:0]             note_amt,
  input  logic                         cancel,
  output logic                         busy,
  output logic                         sel_err,
  output logic                         o_valid,
  output logic                         o_refund,
  output logic [$clog2(NUM_ITEMS)-1:0] o_item,
  output logic [AMT_W-1:0]             o_change
);
  localparam int IW = $clog2(NUM_ITEMS);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_COLLECT  = 2'd1;
  localparam logic [1:0] S_DISPENSE = 2'd2;
  localparam logic [1:0] S_REFUND   = 2'd3;

  logic [1:0]                        state;
  logic [IW-1:0]                     code;
  logic [AMT_W-1:0]                  price;
  logic [AMT_W-1:0]                  credit;
  logic [TW-1:0]                     timer;
  logic [NUM_ITEMS-1:0][AMT_W-1:0]   price_tbl;
  logic [NUM_ITEMS-1:0][7:0]         stock_tbl;

  genvar i;
  generate
    for (i = 0; i < NUM_ITEMS; i++) begin : g_tbl
      vend_tbl_entry #(.AMT_W(AMT_W)) u_entry (
        .clk     (clk),
        .rstn    (rstn),
        .we      (cfg_we && cfg_addr == IW'(i)),
        .dec     (state == S_DISPENSE && code == IW'(i)),
        .price_d (cfg_price),
        .stock_d (cfg_stock),
        .price   (price_tbl[i]),
        .stock   (stock_tbl[i])
      );
    end
  endgenerate

  logic [AMT_W:0]   sum;
  logic [AMT_W-1:0] credit_nxt;
  logic [AMT_W-1:0] credit_eff;
  logic             sel_ok;
  logic             timed_out;

  // Credit saturates at all-ones instead of wrapping.
  always_comb begin
    sum        = {1'b0, credit} + {1'b0, note_amt};
    credit_nxt = sum[AMT_W] ? '1 : sum[AMT_W-1:0];
    credit_eff = note_valid ? credit_nxt : credit;
    sel_ok     = price_tbl[item_code] != '0 && stock_tbl[item_code] != 8'd0;
    timed_out  = !note_valid && timer == TW'(TIMEOUT_CYC - 1);
  end

  assign busy = state != S_IDLE;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      code     <= '0;
      price    <= '0;
      credit   <= '0;
      timer    <= '0;
      sel_err  <= 1'b0;
      o_valid  <= 1'b0;
      o_refund <= 1'b0;
      o_item   <= '0;
      o_change <= '0;
    end else begin
      sel_err  <= 1'b0;
      o_valid  <= 1'b0;
      o_refund <= 1'b0;
      o_item   <= '0;
      o_change <= '0;
      case (state)
        S_IDLE: begin
          if (item_valid) begin
            if (sel_ok) begin
              code   <= item_code;
              price  <= price_tbl[item_code];
              credit <= '0;
              timer  <= '0;
              state  <= S_COLLECT;
            end else begin
              sel_err <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          // Cancel is checked first so a paying note plus cancel still refunds.
          if (cancel || timed_out) begin
            o_refund <= 1'b1;
            o_change <= credit_eff;
            credit   <= '0;
            state    <= S_REFUND;
          end else if (note_valid && credit_nxt >= price) begin
            o_valid  <= 1'b1;
            o_item   <= code;
            o_change <= credit_nxt - price;
            credit   <= '0;
            state    <= S_DISPENSE;
          end else if (note_valid) begin
            credit <= credit_nxt;
            timer  <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DISPENSE: state <= S_IDLE;
        S_REFUND:   state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end
endmodule
